// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold 0..width-1; never below one bit.
  function automatic int cnt_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor (a - b - bin) built from two half subtractors.
// The second stage subtracts the incoming borrow from the first stage's difference.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_sub_cell u_hs0 (
    .a    (a),
    .b    (b),
    .d    (w_d1),
    .bout (w_b1)
  );

  half_sub_cell u_hs1 (
    .a    (w_d1),
    .b    (bin),
    .d    (d),
    .bout (w_b2)
  );

  // At most one of the two stages can borrow, so OR is the combined borrow.
  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/half_sub_cell.sv
// 1-bit half subtractor: d = a - b, borrow raised when b exceeds a.
// Purely combinational building block of the full subtract cell.
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: a - b over WIDTH cycles, LSB first, one shared cell.
// start/busy/done handshake; result, borrow and zero flag are held until the next accepted start.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int             CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_bq;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_shift;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

  // The result register keeps only WIDTH-1 bits: on the final bit the new
  // difference bit and the accumulated bits together form the full result.
  assign w_res_shift = {w_d, r_res_sr};

  full_sub_cell u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_bq),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = start ? RUN : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_bq     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_bq     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_shift[WIDTH-1:1];
      r_bq     <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= w_res_shift;
        r_borrow <= w_bo;
        r_zero   <= (w_res_shift == '0);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed corner cases plus randomized operations
// compared against an arithmetic reference of (a - b) mod 2^W, borrow and zero.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] held_diff;
  logic         held_borrow;
  logic         held_zero;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^W.
  task automatic ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] d, output logic bo, output logic z);
    int r;
    int m;
    r  = int'(x) - int'(y);
    bo = (r < 0);
    m  = (r + (1 << W)) % (1 << W);
    d  = W'(m);
    z  = (m == 0);
  endtask

  // One operation: sampled on negedges, k = cycles after the accepting edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
    ref_sub(av, bv, ed, eb, ez);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k <= W) begin
        check_eq("busy_run", busy, 1'b1);
        check_eq("done_run", done, 1'b0);
        if (k == 1) begin
          check_eq("diff_cleared", diff, '0);
          check_eq("borrow_cleared", borrow, 1'b0);
        end
      end else if (k == W + 1) begin
        check_eq("done_pulse", done, 1'b1);
        check_eq("busy_done", busy, 1'b0);
        check_eq("diff", diff, ed);
        check_eq("borrow", borrow, eb);
        check_eq("zero", zero, ez);
      end else begin
        check_eq("done_single", done, 1'b0);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("diff_held", diff, ed);
      end
      a = W'($urandom);
      b = W'($urandom);
      start = (noise && k < W) ? 1'b1 : 1'b0;
    end
    held_diff   = ed;
    held_borrow = eb;
    held_zero   = ez;
    $display("op a=0x%02h b=0x%02h noise=%0d -> diff=0x%02h borrow=%0d zero=%0d (ref 0x%02h %0d %0d)",
             av, bv, noise, diff, borrow, zero, ed, eb, ez);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_diff_held", diff, held_diff);
      check_eq("idle_borrow_held", borrow, held_borrow);
      check_eq("idle_zero_held", zero, held_zero);
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    a     = 8'h77;
    b     = 8'h11;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("busy_pre_rst", busy, 1'b1);
      start = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_diff", diff, '0);
    check_eq("rst_borrow", borrow, 1'b0);
    check_eq("rst_zero", zero, 1'b0);
    held_diff   = '0;
    held_borrow = 1'b0;
    held_zero   = 1'b0;
    idle_gap(W + 2);
    $display("op reset during RUN -> busy=%0d done=%0d diff=0x%02h", busy, done, diff);
  endtask

  task automatic back_to_back();
    int n_done;
    n_done = 0;
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h01;
    start = 1'b1;
    for (int k = 1; k <= 3 * (W + 1); k++) begin
      @(negedge clk);
      check_eq("b2b_done", done, (k % (W + 1)) == 0);
      check_eq("b2b_busy", busy, (k % (W + 1)) != 0);
      if ((k % (W + 1)) == 0) begin
        n_done++;
        check_eq("b2b_diff", diff, 8'hFE);
        check_eq("b2b_borrow", borrow, 1'b0);
        $display("op b2b #%0d a=0xff b=0x01 -> diff=0x%02h borrow=%0d", n_done, diff, borrow);
      end
      if (k == 3 * (W + 1)) start = 1'b0;
    end
    held_diff   = 8'hFE;
    held_borrow = 1'b0;
    held_zero   = 1'b0;
    idle_gap(2);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    held_diff   = '0;
    held_borrow = 1'b0;
    held_zero   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_diff", diff, '0);
    check_eq("reset_borrow", borrow, 1'b0);
    check_eq("reset_zero", zero, 1'b0);
    rst = 1'b0;
    idle_gap(2);

    run_op(8'h5A, 8'h23, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h3C, 8'h3C, 1'b0);
    run_op(8'h81, 8'h7E, 1'b1);
    run_op(8'hFF, 8'h00, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    idle_gap(1);
    reset_mid_run();
    run_op(8'hC3, 8'h3C, 1'b0);
    back_to_back();

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      idle_gap($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
